mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction fetch
// stage and the MEM (load/store) stage of a pipeline.
//
// Data requests normally win over fetches. If the last completed grant went to
// DATA and a fetch is pending, the fetch wins instead, so neither side can be
// starved. Every access is registered: the address, store data and write enable
// are latched on the grant edge and held stable until mem_ready. A wait counter
// bounds each access. When it reaches TIMEOUT the arbiter locks into a terminal
// error state, and only reset clears that state.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   if_req, if_addr      fetch request and PC
//   MemRd, MemWr         MEM stage load / store request (both high = store)
//   d_addr, d_wdata      load/store address and store data
//   mem_ready, mem_rdata memory completion strobe and read data
//   mem_req, mem_we      registered memory request / write enable
//   mem_addr, mem_wdata  registered memory address / store data
//   if_inst, d_rdata     captured instruction / load data
//   if_done, d_done      one-cycle completion pulses
//   if_stall, d_stall    combinational stalls to IF / MEM
//   bus_err              sticky timeout flag
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned AW      = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          MemRd,
    input  logic          MemWr,
    input  logic [AW-1:0] d_addr,
    input  logic [AW-1:0] d_wdata,
    input  logic          mem_ready,
    input  logic [AW-1:0] mem_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_wdata,
    output logic [AW-1:0] if_inst,
    output logic [AW-1:0] d_rdata,
    output logic          if_done,
    output logic          d_done,
    output logic          if_stall,
    output logic          d_stall,
    output logic          bus_err
);

    // The wait counter is at least 8 bits wide and grows if TIMEOUT needs more.
    localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] LastWait = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StInst,
        StErr
    } state_e;

    state_e          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [AW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [AW-1:0]   if_inst_q, if_inst_d;
    logic [AW-1:0]   d_rdata_q, d_rdata_d;
    logic            if_done_q, if_done_d;
    logic            d_done_q, d_done_d;
    logic            bus_err_q, bus_err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_data_q, last_data_d;  // last completed grant was DATA

    logic data_req;
    assign data_req = MemRd | MemWr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_inst_q   <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            cnt_q       <= '0;
            last_data_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_inst_q   <= if_inst_d;
            d_rdata_q   <= d_rdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            bus_err_q   <= bus_err_d;
            cnt_q       <= cnt_d;
            last_data_q <= last_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_inst_d   = if_inst_q;
        d_rdata_d   = d_rdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        bus_err_d   = bus_err_q;
        cnt_d       = cnt_q;
        last_data_d = last_data_q;

        case (state_q)
            StIdle: begin
                // mem_ready is ignored here.
                if (data_req && !(last_data_q && if_req)) begin
                    state_d     = StData;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWr;  // MemRd & MemWr together acts as a store
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    cnt_d       = '0;
                end else if (if_req) begin
                    // A fetch keeps the previous mem_wdata.
                    state_d    = StInst;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    cnt_d      = '0;
                end
            end
            StData, StInst: begin
                if (mem_ready) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    if (state_q == StData) begin
                        d_done_d    = 1'b1;
                        last_data_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_done_d   = 1'b1;
                        last_data_d = 1'b0;
                        if_inst_d   = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LastWait) begin
                        state_d   = StErr;
                        mem_req_d = 1'b0;
                        bus_err_d = 1'b1;
                    end
                end
            end
            StErr: begin
                // Terminal state. Only reset leaves it.
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_inst   = if_inst_q;
    assign d_rdata   = d_rdata_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign bus_err   = bus_err_q;

    // Both stages are held for good once the bus has timed out.
    assign d_stall  = (data_req & ~d_done_q) | (state_q == StErr);
    assign if_stall = (if_req & ~if_done_q) | (state_q == StErr);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        MemRd;
    logic        MemWr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] if_inst;
    logic [31:0] d_rdata;
    logic        if_done;
    logic        d_done;
    logic        if_stall;
    logic        d_stall;
    logic        bus_err;

    mem_arbiter #(
        .TIMEOUT(4),
        .AW     (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .MemRd    (MemRd),
        .MemWr    (MemWr),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .if_inst  (if_inst),
        .d_rdata  (d_rdata),
        .if_done  (if_done),
        .d_done   (d_done),
        .if_stall (if_stall),
        .d_stall  (d_stall),
        .bus_err  (bus_err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } grant_t;

    grant_t      exp_q[$];     // expected grants, pushed when a request is driven
    logic [31:0] exp_rd_q[$];  // expected captured read data
    grant_t      g;
    logic [31:0] exp_wdata;    // model of the latched mem_wdata
    logic [31:0] exp_d_rdata;  // model of d_rdata
    int          n_cmp = 0;
    int          n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; MemRd = 1'b0; MemWr = 1'b0;
        d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        exp_wdata = '0; exp_d_rdata = '0;
        #3;
        cyc(); cyc();
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
        n_cmp++; if (if_inst !== 32'h0) begin n_err++; $display("FAIL rst_if_inst got=%h exp=0", if_inst); end
        n_cmp++; if (d_rdata !== 32'h0) begin n_err++; $display("FAIL rst_d_rdata got=%h exp=0", d_rdata); end
        n_cmp++; if ({if_done, d_done, bus_err} !== 3'b000) begin n_err++; $display("FAIL rst_flags got=%b exp=000", {if_done, d_done, bus_err}); end
        rst_n = 1'b1;
        // mem_ready while IDLE must not produce anything.
        mem_ready = 1'b1; mem_rdata = 32'h5555AAAA;
        cyc(); cyc();
        mem_ready = 1'b0;
        n_cmp++; if ({mem_req, if_done, d_done} !== 3'b000) begin n_err++; $display("FAIL idle_ready got=%b exp=000", {mem_req, if_done, d_done}); end
        n_cmp++; if (if_inst !== 32'h0) begin n_err++; $display("FAIL idle_ready_inst got=%h exp=0", if_inst); end
    endtask

    task automatic test_fetch();
        int t;
        if_req = 1'b1; if_addr = 32'h40;
        exp_q.push_back('{addr: 32'h40, we: 1'b0, wdata: exp_wdata});
        exp_rd_q.push_back(32'h8C010004);
        t = 0;
        do begin cyc(); t++; end while (!mem_req && t < 8);
        n_cmp++; if (mem_req !== 1'b1 || t !== 1) begin n_err++; $display("FAIL fetch_grant got req=%b after %0d exp req=1 after 1", mem_req, t); end
        g = exp_q.pop_front();
        n_cmp++; if (mem_addr !== g.addr) begin n_err++; $display("FAIL fetch_addr got=%h exp=%h", mem_addr, g.addr); end
        n_cmp++; if (mem_we !== g.we) begin n_err++; $display("FAIL fetch_we got=%b exp=%b", mem_we, g.we); end
        n_cmp++; if (mem_wdata !== g.wdata) begin n_err++; $display("FAIL fetch_wdata got=%h exp=%h", mem_wdata, g.wdata); end
        n_cmp++; if (if_stall !== 1'b1) begin n_err++; $display("FAIL fetch_stall0 got=%b exp=1", if_stall); end
        cyc();
        n_cmp++; if ({mem_req, if_done, if_stall} !== 3'b101 || mem_addr !== 32'h40) begin n_err++; $display("FAIL fetch_wait got req/done/stall=%b addr=%h exp=101 addr=40", {mem_req, if_done, if_stall}, mem_addr); end
        cyc();
        n_cmp++; if ({mem_req, if_done, if_stall} !== 3'b101) begin n_err++; $display("FAIL fetch_wait2 got=%b exp=101", {mem_req, if_done, if_stall}); end
        mem_ready = 1'b1; mem_rdata = 32'h8C010004;
        cyc();
        mem_ready = 1'b0; mem_rdata = 32'hFFFFFFFF;
        n_cmp++; if ({mem_req, if_done, if_stall} !== 3'b010) begin n_err++; $display("FAIL fetch_done got req/done/stall=%b exp=010", {mem_req, if_done, if_stall}); end
        n_cmp++; if (if_inst !== exp_rd_q[0]) begin n_err++; $display("FAIL fetch_inst got=%h exp=%h", if_inst, exp_rd_q[0]); end
        void'(exp_rd_q.pop_front());
        if_req = 1'b0;
        cyc();
        n_cmp++; if ({if_done, if_stall, mem_req} !== 3'b000) begin n_err++; $display("FAIL fetch_after got=%b exp=000", {if_done, if_stall, mem_req}); end
    endtask

    task automatic test_data_access(input logic rd, input logic wr, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [31:0] rdata);
        int t;
        MemRd = rd; MemWr = wr; d_addr = addr; d_wdata = wdata;
        exp_q.push_back('{addr: addr, we: wr, wdata: wdata});
        exp_wdata = wdata;
        if (!wr) exp_d_rdata = rdata;
        t = 0;
        do begin cyc(); t++; end while (!mem_req && t < 8);
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL data_grant rd=%b wr=%b got req=0 exp=1", rd, wr); end
        g = exp_q.pop_front();
        n_cmp++; if (mem_addr !== g.addr || mem_we !== g.we || mem_wdata !== g.wdata) begin
            n_err++; $display("FAIL data_latch got addr=%h we=%b wdata=%h exp addr=%h we=%b wdata=%h",
                              mem_addr, mem_we, mem_wdata, g.addr, g.we, g.wdata);
        end
        n_cmp++; if (d_stall !== 1'b1) begin n_err++; $display("FAIL data_stall got=%b exp=1", d_stall); end
        mem_ready = 1'b1; mem_rdata = rdata;
        cyc();
        mem_ready = 1'b0;
        n_cmp++; if ({d_done, d_stall, mem_req, if_done} !== 4'b1000) begin n_err++; $display("FAIL data_done got done/stall/req/ifdone=%b exp=1000", {d_done, d_stall, mem_req, if_done}); end
        n_cmp++; if (d_rdata !== exp_d_rdata) begin n_err++; $display("FAIL data_rdata rd=%b wr=%b got=%h exp=%h", rd, wr, d_rdata, exp_d_rdata); end
        MemRd = 1'b0; MemWr = 1'b0;
        cyc();
        n_cmp++; if (d_done !== 1'b0) begin n_err++; $display("FAIL data_pulse got=%b exp=0", d_done); end
    endtask

    task automatic test_alternation();
        int t;
        logic [31:0] v;
        rst_n = 1'b0; #1;
        cyc();
        rst_n = 1'b1;
        exp_wdata = '0; exp_d_rdata = '0;
        if_req = 1'b1; if_addr = 32'h80; MemRd = 1'b1; d_addr = 32'h300; d_wdata = '0;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{addr: (k % 2 == 0) ? 32'h300 : 32'h80, we: 1'b0, wdata: 32'h0});
        end
        for (int k = 0; k < 4; k++) begin
            t = 0;
            do begin cyc(); t++; end while (!mem_req && t < 8);
            n_cmp++; if (mem_req !== 1'b1 || t !== 1) begin n_err++; $display("FAIL alt_gap%0d got req=%b after %0d exp req=1 after 1", k, mem_req, t); end
            g = exp_q.pop_front();
            n_cmp++; if (mem_addr !== g.addr || mem_we !== g.we) begin n_err++; $display("FAIL alt_order%0d got addr=%h we=%b exp addr=%h we=%b", k, mem_addr, mem_we, g.addr, g.we); end
            v = 32'hA0000000 + 32'(k);
            mem_ready = 1'b1; mem_rdata = v;
            cyc();
            mem_ready = 1'b0;
            if (k % 2 == 0) begin
                n_cmp++; if (d_done !== 1'b1 || if_done !== 1'b0 || d_rdata !== v) begin n_err++; $display("FAIL alt_data%0d got done=%b ifdone=%b rdata=%h exp 1 0 %h", k, d_done, if_done, d_rdata, v); end
            end else begin
                n_cmp++; if (if_done !== 1'b1 || d_done !== 1'b0 || if_inst !== v) begin n_err++; $display("FAIL alt_inst%0d got done=%b ddone=%b inst=%h exp 1 0 %h", k, if_done, d_done, if_inst, v); end
            end
            if (k == 3) begin
                if_req = 1'b0; MemRd = 1'b0;
            end
        end
        cyc();
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL alt_end got req=%b exp=0", mem_req); end
    endtask

    task automatic test_reset_mid();
        int t;
        MemRd = 1'b1; d_addr = 32'h400;
        t = 0;
        do begin cyc(); t++; end while (!mem_req && t < 8);
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rmid_grant got=%b exp=1", mem_req); end
        cyc();
        rst_n = 1'b0; #1;
        n_cmp++; if ({mem_req, d_done} !== 2'b00 || mem_addr !== 32'h0) begin n_err++; $display("FAIL rmid_async got req/done=%b addr=%h exp=00 addr=0", {mem_req, d_done}, mem_addr); end
        MemRd = 1'b0;
        cyc();
        rst_n = 1'b1;
        mem_ready = 1'b1; mem_rdata = 32'h77777777;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++; if ({mem_req, d_done, if_done} !== 3'b000 || d_rdata !== 32'h0) begin n_err++; $display("FAIL rmid_after%0d got req/done/ifdone=%b rdata=%h exp=000 rdata=0", i, {mem_req, d_done, if_done}, d_rdata); end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int t;
        int c;
        if_req = 1'b1; if_addr = 32'h500;
        t = 0;
        do begin cyc(); t++; end while (!mem_req && t < 8);
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL tmo_grant got=%b exp=1", mem_req); end
        c = 1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (mem_req) c++;
            else break;
        end
        n_cmp++; if (c !== 4) begin n_err++; $display("FAIL tmo_wait_cycles got=%0d exp=4", c); end
        n_cmp++; if ({bus_err, mem_req, if_stall, d_stall} !== 4'b1011) begin n_err++; $display("FAIL tmo_err got err/req/istall/dstall=%b exp=1011", {bus_err, mem_req, if_stall, d_stall}); end
        if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h12121212;
        cyc(); cyc();
        mem_ready = 1'b0; MemRd = 1'b1;
        cyc(); cyc();
        n_cmp++; if ({bus_err, mem_req, if_stall, d_stall, if_done, d_done} !== 6'b101100) begin n_err++; $display("FAIL tmo_sticky got=%b exp=101100", {bus_err, mem_req, if_stall, d_stall, if_done, d_done}); end
        MemRd = 1'b0;
        rst_n = 1'b0; #1;
        n_cmp++; if ({bus_err, if_stall, d_stall} !== 3'b000) begin n_err++; $display("FAIL tmo_reset got err/istall/dstall=%b exp=000", {bus_err, if_stall, d_stall}); end
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_data_access(1'b1, 1'b0, 32'h200, 32'h11112222, 32'h12345678);  // load
        test_data_access(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 32'hBAD0BAD0);  // store
        test_data_access(1'b1, 1'b1, 32'h104, 32'hCAFEF00D, 32'h0BADF00D);  // rd+wr = store
        test_fetch();  // mem_wdata must still hold the last store data
        test_alternation();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
